// File: rtl/fifo_rd_unpack.sv
// fifo_rd_unpack: read-domain consumer for the dual-clock FIFO.
// It pops FWFT words and splits each one into DSIZE/OSIZE narrower lanes.
// The lanes are presented on a valid/ready stream, one lane per cycle.
// Consecutive FIFO words are emitted without a bubble between them.
module fifo_rd_unpack #(
  parameter int DSIZE     = 32,
  parameter int OSIZE     = 16,
  parameter     LSB_FIRST = "TRUE",
  parameter int CSIZE     = 16
) (
  input  logic              rclk,
  input  logic              rrst,
  input  logic              flush,
  input  logic [DSIZE-1:0]  rdata,
  input  logic              rempty,
  output logic              rinc,
  output logic [OSIZE-1:0]  m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic [CSIZE-1:0]  words_popped
);

  localparam int            NL        = DSIZE / OSIZE;
  localparam int            LW        = (NL > 1) ? $clog2(NL) : 1;
  localparam bit            LSBF      = (LSB_FIRST == "TRUE");
  localparam logic [LW-1:0] LAST_LANE = LW'(NL - 1);

  logic [DSIZE-1:0] word_buf;
  logic             buf_valid;
  logic [LW-1:0]    lane;
  logic [CSIZE-1:0] cnt;

  logic             lane_last;
  logic             fire;
  logic             done;
  logic [LW-1:0]    lane_sel;

  assign lane_last = (lane == LAST_LANE);
  assign fire      = buf_valid & m_ready;
  assign done      = fire & lane_last;

  // A new word is popped only when the buffer is free or is handing off its final lane this cycle.
  assign rinc = ~rrst & ~flush & ~rempty & (~buf_valid | done);

  assign m_valid      = buf_valid;
  assign m_last       = buf_valid & lane_last;
  assign words_popped = cnt;

  // The physical slice index walks upward for LSB-first order and downward for MSB-first order.
  assign lane_sel = LSBF ? lane : (LAST_LANE - lane);

  // Select the current lane out of the buffered word.
  always_comb begin
    m_data = '0;
    for (int i = 0; i < NL; i++) begin
      if (lane_sel == LW'(i)) begin
        m_data = word_buf[i*OSIZE +: OSIZE];
      end
    end
  end

  // Buffer, lane and pop-counter updates: reset, then flush, then pop/advance.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      word_buf  <= '0;
      buf_valid <= 1'b0;
      lane      <= '0;
      cnt       <= '0;
    end else if (flush) begin
      buf_valid <= 1'b0;
      lane      <= '0;
    end else if (rinc) begin
      word_buf  <= rdata;
      buf_valid <= 1'b1;
      lane      <= '0;
      cnt       <= cnt + CSIZE'(1);
    end else if (done) begin
      buf_valid <= 1'b0;
      lane      <= '0;
    end else if (fire) begin
      lane      <= lane + LW'(1);
    end
  end

endmodule

// File: tb/tb_fifo_rd_unpack.sv
// tb_fifo_rd_unpack: randomized self-checking bench for fifo_rd_unpack.
// The reference model is a queue of words waiting in the FIFO plus a queue of lanes still owed downstream.
// Two instances are exercised: the default LSB-first 16-bit counter, and an MSB-first variant with a 2-bit counter.
module tb_fifo_rd_unpack;

  logic        clk = 1'b0;
  logic        rrst_a, rrst_b;
  logic        flush;
  logic [31:0] rdata;
  logic        rempty;
  logic        m_ready;

  logic        rinc_a, m_valid_a, m_last_a;
  logic [15:0] m_data_a;
  logic [15:0] wp_a;
  logic        rinc_b, m_valid_b, m_last_b;
  logic [15:0] m_data_b;
  logic [1:0]  wp_b;

  bit          sel;
  bit          lsb;
  int          cmask;
  int          cnt;
  logic [31:0] fifo[$];
  logic [15:0] pend[$];

  int          checks = 0;
  int          errors = 0;

  logic        obs_rinc, obs_valid, obs_last;
  logic [15:0] obs_data;
  logic [31:0] obs_cnt;

  always #5 clk = ~clk;

  fifo_rd_unpack #(.DSIZE(32), .OSIZE(16), .LSB_FIRST("TRUE"), .CSIZE(16)) dut_a (
    .rclk(clk), .rrst(rrst_a), .flush(flush), .rdata(rdata), .rempty(rempty),
    .rinc(rinc_a), .m_data(m_data_a), .m_valid(m_valid_a), .m_ready(m_ready),
    .m_last(m_last_a), .words_popped(wp_a)
  );

  fifo_rd_unpack #(.DSIZE(32), .OSIZE(16), .LSB_FIRST("FALSE"), .CSIZE(2)) dut_b (
    .rclk(clk), .rrst(rrst_b), .flush(flush), .rdata(rdata), .rempty(rempty),
    .rinc(rinc_b), .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready),
    .m_last(m_last_b), .words_popped(wp_b)
  );

  assign obs_rinc  = sel ? rinc_b    : rinc_a;
  assign obs_valid = sel ? m_valid_b : m_valid_a;
  assign obs_last  = sel ? m_last_b  : m_last_a;
  assign obs_data  = sel ? m_data_b  : m_data_a;
  assign obs_cnt   = sel ? {30'd0, wp_b} : {16'd0, wp_a};

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Queue the lanes of a popped word in the order the active instance should emit them.
  function automatic void pushLanes(input logic [31:0] w);
    logic [15:0] lo;
    logic [15:0] hi;
    lo = w[15:0];
    hi = w[31:16];
    if (lsb) begin
      pend.push_back(lo);
      pend.push_back(hi);
    end else begin
      pend.push_back(hi);
      pend.push_back(lo);
    end
  endfunction

  // One clock cycle: drive inputs, check outputs against the model, then advance the model at the edge.
  task automatic applyStimulus(input bit rst, input bit fl, input bit rdy, input bit hide);
    bit busy;
    bit exp_fire;
    bit exp_rinc;
    if (sel) rrst_b = rst;
    else     rrst_a = rst;
    flush   = fl;
    m_ready = rdy;
    rempty  = (fifo.size() == 0) || hide;
    rdata   = (fifo.size() != 0) ? fifo[0] : $urandom();
    #1;
    busy     = (pend.size() != 0);
    exp_fire = busy && rdy;
    exp_rinc = !rst && !fl && !rempty && (!busy || (exp_fire && pend.size() == 1));
    checkOutput("rinc", {31'd0, obs_rinc}, {31'd0, exp_rinc});
    if (!rst) begin
      checkOutput("m_valid", {31'd0, obs_valid}, {31'd0, busy});
      checkOutput("m_last", {31'd0, obs_last}, {31'd0, (pend.size() == 1)});
      if (busy) checkOutput("m_data", {16'd0, obs_data}, {16'd0, pend[0]});
      checkOutput("words_popped", obs_cnt, cnt);
    end
    @(posedge clk);
    if (rst) begin
      pend.delete();
      cnt = 0;
    end else if (fl) begin
      pend.delete();
    end else begin
      if (exp_fire) void'(pend.pop_front());
      if (exp_rinc) begin
        pushLanes(fifo.pop_front());
        cnt = (cnt + 1) & cmask;
      end
    end
    @(negedge clk);
  endtask

  task automatic runRandom(input int cycles);
    bit rst;
    bit fl;
    bit rdy;
    bit hide;
    for (int i = 0; i < cycles; i++) begin
      if (fifo.size() < 4 && $urandom_range(1, 0) == 1) fifo.push_back($urandom());
      rst  = ($urandom_range(99, 0) == 0);
      fl   = ($urandom_range(19, 0) == 0);
      rdy  = ($urandom_range(3, 0) != 0);
      hide = ($urandom_range(4, 0) == 0);
      applyStimulus(rst, fl, rdy, hide);
    end
  endtask

  initial begin
    rrst_a  = 1'b1;
    rrst_b  = 1'b1;
    flush   = 1'b0;
    m_ready = 1'b1;
    rdata   = '0;
    rempty  = 1'b1;
    sel     = 1'b0;
    lsb     = 1'b1;
    cmask   = 32'hFFFF;
    cnt     = 0;
    @(negedge clk);

    $display("[TB] LSB-first instance: reset and idle");
    repeat (2) applyStimulus(1, 0, 1, 0);
    checkOutput("m_data_after_reset", {16'd0, obs_data}, 32'd0);
    repeat (10) applyStimulus(0, 0, 1, 0);

    $display("[TB] single word split");
    fifo.push_back(32'hDEADBEEF);
    repeat (4) applyStimulus(0, 0, 1, 0);
    checkOutput("popped_after_single", obs_cnt, 32'd1);

    $display("[TB] back-to-back words");
    fifo.push_back(32'h11112222);
    fifo.push_back(32'h33334444);
    fifo.push_back(32'h55556666);
    repeat (8) applyStimulus(0, 0, 1, 0);

    $display("[TB] backpressure on lane 1");
    fifo.push_back(32'hAAAA5555);
    fifo.push_back(32'h12345678);
    repeat (2) applyStimulus(0, 0, 1, 0);
    repeat (5) applyStimulus(0, 0, 0, 0);
    repeat (5) applyStimulus(0, 0, 1, 0);

    $display("[TB] flush with lane 1 pending");
    fifo.push_back(32'hCAFEF00D);
    fifo.push_back(32'h0BADBEEF);
    repeat (2) applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0);
    repeat (5) applyStimulus(0, 0, 1, 0);

    $display("[TB] LSB-first random traffic");
    runRandom(400);

    $display("[TB] MSB-first instance with 2-bit counter");
    rrst_a = 1'b1;
    sel    = 1'b1;
    lsb    = 1'b0;
    cmask  = 3;
    fifo.delete();
    repeat (2) applyStimulus(1, 0, 1, 0);
    checkOutput("m_data_after_reset_b", {16'd0, obs_data}, 32'd0);
    for (int i = 0; i < 5; i++) fifo.push_back(32'hA0B0C0D0 + i * 32'h01010101);
    repeat (12) applyStimulus(0, 0, 1, 0);
    checkOutput("popped_wrap_b", obs_cnt, 32'd1);

    $display("[TB] MSB-first random traffic");
    runRandom(400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
